// File: rtl/municao_multi.sv
// Multi-slot projectile engine: fire/launch, per-frame upward motion with retirement,
// and a registered white-on-black overlay for the pixel currently being scanned.
module municao_multi #(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 4,
    parameter int BULLET_W  = 2,
    parameter int BULLET_H  = 20,
    parameter int SPAWN_Y   = 489,
    parameter int TOP_LIMIT = 3,
    parameter int H_BLANK   = 96,
    parameter int V_BLANK   = 2,
    localparam int CW       = $clog2(NUM_SLOTS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    h_counter,
    input  logic [9:0]    v_counter,
    input  logic          frame_tick,
    input  logic          fire,
    input  logic [10:0]   fire_x,
    input  logic          clear,
    output logic          fire_ready,
    output logic [CW-1:0] active_count,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B
);
    localparam logic [9:0]  RETIRE_Y = 10'(TOP_LIMIT + SPEED);
    localparam logic [9:0]  SPEED_V  = 10'(SPEED);
    localparam logic [9:0]  SPAWN_V  = 10'(SPAWN_Y);
    localparam logic [11:0] BW12     = 12'(BULLET_W);
    localparam logic [11:0] BH12     = 12'(BULLET_H);
    localparam logic [9:0]  HB       = 10'(H_BLANK);
    localparam logic [9:0]  VB       = 10'(V_BLANK);

    logic [NUM_SLOTS-1:0]       act_q, act_d;
    logic [NUM_SLOTS-1:0][10:0] x_q, x_d;
    logic [NUM_SLOTS-1:0][9:0]  y_q, y_d;
    logic [NUM_SLOTS-1:0]       load;
    logic [CW-1:0]              cnt;
    logic                       taken;
    logic                       hit, lit_d, lit_q;
    logic [10:0]                h11, v11;

    // Load target comes from registered occupancy only, so a slot freed by
    // this cycle's frame_tick cannot be refilled until the following cycle.
    always_comb begin
        load  = '0;
        taken = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!act_q[i] && !taken) begin
                load[i] = fire;
                taken   = 1'b1;
            end
        end
    end

    always_comb begin
        act_d = act_q;
        x_d   = x_q;
        y_d   = y_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clear) begin
                act_d[i] = 1'b0;
            end else if (load[i]) begin
                act_d[i] = 1'b1;
                x_d[i]   = fire_x;
                y_d[i]   = SPAWN_V;
            end else if (frame_tick && act_q[i]) begin
                if (y_q[i] >= RETIRE_Y) y_d[i] = y_q[i] - SPEED_V;
                else                    act_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) cnt = cnt + CW'(act_q[i]);
    end

    assign fire_ready   = ~&act_q;
    assign active_count = cnt;

    // Right/bottom edges are formed in 12 bits so x near 2047 cannot wrap.
    assign h11 = {1'b0, h_counter};
    assign v11 = {1'b0, v_counter};

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (act_q[i] &&
                (h11 >= x_q[i]) && ({1'b0, h11} < ({1'b0, x_q[i]} + BW12)) &&
                (v11 >= {1'b0, y_q[i]}) && ({1'b0, v11} < ({2'b0, y_q[i]} + BH12)))
                hit = 1'b1;
        end
    end

    assign lit_d = (h_counter > HB) && (v_counter > VB) && hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            lit_q <= 1'b0;
        end else begin
            act_q <= act_d;
            x_q   <= x_d;
            y_q   <= y_d;
            lit_q <= lit_d;
        end
    end

    assign R = {8{lit_q}};
    assign G = {8{lit_q}};
    assign B = {8{lit_q}};
endmodule

// File: tb/tb_municao_multi.sv
// Bench for municao_multi: directed scenarios plus randomized traffic against a slot-list model.
module tb_municao_multi;
    localparam int NS = 4, SPEED = 4, BW = 2, BH = 20, SPAWN = 489, TOPL = 3, HB = 96, VB = 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic [9:0]  h_counter = '0, v_counter = '0;
    logic        frame_tick = 1'b0, fire = 1'b0, clear = 1'b0;
    logic [10:0] fire_x = '0;
    logic        fire_ready;
    logic [2:0]  active_count;
    logic [7:0]  R, G, B;

    int checks = 0, errors = 0;
    bit m_act[NS];
    int m_x[NS], m_y[NS];

    always #5 clk = ~clk;

    municao_multi dut (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .frame_tick(frame_tick), .fire(fire), .fire_x(fire_x), .clear(clear),
        .fire_ready(fire_ready), .active_count(active_count), .R(R), .G(G), .B(B)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NS; i++) n += m_act[i];
        return n;
    endfunction

    function automatic bit m_lit(input int h, input int v);
        bit any = 0;
        if (h <= HB || v <= VB) return 0;
        for (int i = 0; i < NS; i++)
            if (m_act[i] && h >= m_x[i] && h < m_x[i] + BW && v >= m_y[i] && v < m_y[i] + BH) any = 1;
        return any;
    endfunction

    task automatic m_step(input bit f, input int fx, input bit t, input bit c);
        int free = -1;
        if (c) begin
            for (int i = 0; i < NS; i++) m_act[i] = 0;
            return;
        end
        for (int i = 0; i < NS; i++) if (!m_act[i] && free < 0) free = i;
        for (int i = 0; i < NS; i++)
            if (m_act[i] && t) begin
                if (m_y[i] >= TOPL + SPEED) m_y[i] -= SPEED;
                else m_act[i] = 0;
            end
        if (f && free >= 0) begin
            m_act[free] = 1; m_x[free] = fx; m_y[free] = SPAWN;
        end
    endtask

    // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
    task automatic cyc(input bit f, input int fx, input bit t, input bit c, input int h, input int v);
        bit exp_lit;
        fire = f; fire_x = 11'(fx); frame_tick = t; clear = c;
        h_counter = 10'(h); v_counter = 10'(v);
        exp_lit = m_lit(h, v);
        m_step(f, fx, t, c);
        @(posedge clk); #1;
        chk("rgb", int'({R, G, B}), exp_lit ? 24'hFFFFFF : 0);
        chk("count", int'(active_count), m_cnt());
        chk("ready", int'(fire_ready), (m_cnt() < NS) ? 1 : 0);
        fire = 0; frame_tick = 0; clear = 0;
    endtask

    task automatic do_reset();
        fire = 1; fire_x = 11'd123;
        reset = 0; #1;
        for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        chk("rst_rgb", int'({R, G, B}), 0);
        chk("rst_count", int'(active_count), 0);
        chk("rst_ready", int'(fire_ready), 1);
        fire = 0; #1;
        reset = 1;
    endtask

    initial begin
        int s, h, v;
        #2;
        chk("por_rgb", int'({R, G, B}), 0);
        chk("por_count", int'(active_count), 0);
        chk("por_ready", int'(fire_ready), 1);
        #1 reset = 1;

        // single projectile launch and pixel probes
        cyc(1, 300, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 300, 489);
        cyc(0, 0, 0, 0, 302, 489);
        cyc(0, 0, 0, 0, 50, 489);
        cyc(0, 0, 0, 0, 301, 508);
        cyc(0, 0, 0, 0, 301, 509);
        cyc(0, 0, 0, 0, 299, 500);

        // fill all slots, fifth fire ignored
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 200 + 10 * i, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 200 + 10 * i, 495);

        // full flight: 121 ticks then retire on the 122nd
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 400, 0, 0, 0, 0);
        for (int i = 0; i < 121; i++) cyc(0, 0, 1, 0, 400, 5 + (i % 25));
        cyc(0, 0, 0, 0, 400, 5);
        cyc(0, 0, 0, 0, 401, 24);
        cyc(0, 0, 1, 0, 400, 5);

        // slot1 retires while full; same-cycle fire ignored, next fire refills slot1
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 500, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 520, 0, 0, 0, 0);
        for (int i = 0; i < 92; i++) cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 540, 0, 0, 0, 0);
        cyc(1, 560, 0, 0, 0, 0);
        cyc(1, 580, 0, 0, 0, 0);
        for (int i = 0; i < 29; i++) cyc(0, 0, 1, 0, 520, 10);
        cyc(1, 700, 1, 0, 520, 5);
        cyc(1, 800, 0, 0, 700, 489);
        cyc(0, 0, 0, 0, 800, 489);
        cyc(0, 0, 0, 0, 700, 489);

        // clear beats fire and frame_tick
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 150, 0, 0, 0, 0);
        cyc(1, 160, 0, 0, 0, 0);
        cyc(1, 170, 1, 1, 150, 489);
        cyc(0, 0, 0, 0, 170, 489);

        // async reset mid-frame with 3 active, lit pixel on screen
        cyc(1, 1000, 0, 0, 0, 0);
        cyc(1, 1023, 0, 0, 0, 0);
        cyc(1, 2047, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1023, 490);
        do_reset();
        cyc(1, 333, 0, 0, 1023, 490);
        cyc(0, 0, 0, 0, 334, 500);

        // randomized traffic with probes biased toward live projectiles
        for (int n = 0; n < 600; n++) begin
            h = $urandom_range(0, 1023);
            v = $urandom_range(0, 1023);
            s = $urandom_range(0, NS - 1);
            if (m_act[s] && ($urandom_range(0, 3) != 0)) begin
                h = m_x[s] + $urandom_range(0, 3) - 1;
                v = m_y[s] + $urandom_range(0, 21) - 1;
                if (h < 0) h = 0; if (h > 1023) h = 1023;
                if (v < 0) v = 0; if (v > 1023) v = 1023;
            end
            cyc($urandom_range(0, 3) == 0,
                ($urandom_range(0, 15) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 1023),
                $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, h, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
